fp_add_sub_pipe: RTL and testbench

Pipelined, parametrised IEEE-754-style floating-point adder/subtractor with valid/ready handshakes on both sides. It generalises the combinational single-precision add/sub to any exponent/mantissa width. It adds guard/round/sticky rounding, overflow-to-infinity, and backpressure. It sits between the operand-fetch logic and the iteration datapath of the Newton-Raphson solver, and accepts one operation per cycle when unstalled.

---
 rtl/fp_add_sub_pipe.sv | 238 +++++++++++++++++++++++
 tb/tb_fp_add_sub_pipe.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_add_sub_pipe.sv
`default_nettype none
// ============================================================================
// Module   : fp_add_sub_pipe
// Purpose  : Pipelined, parametrised floating-point adder/subtractor with
//            valid/ready handshakes (input capture + align/add/normalise).
//            Define FP_ADDSUB_RNE_EN for round-to-nearest-even; otherwise the
//            result is truncated (round toward zero).
// Revision : 1.0  initial release
// ============================================================================
module fp_add_sub_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   a_operand,
    input  logic [EXP_W+MAN_W:0]   b_operand,
    input  logic                   AddBar_Sub,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   result,
    output logic                   Exception
);

    localparam int C_W     = 1 + EXP_W + MAN_W;
    localparam int C_SIG_W = MAN_W + 4;
    localparam int C_SUM_W = MAN_W + 5;
    localparam int C_LZ_W  = $clog2(C_SIG_W + 1);
    localparam int C_CMP_W = ((EXP_W > C_LZ_W) ? EXP_W : C_LZ_W) + 1;
    localparam logic [EXP_W-1:0] C_EXP_ONES = '1;
    localparam logic [EXP_W-1:0] C_EXP_ONE  = EXP_W'(1);
`ifdef FP_ADDSUB_RNE_EN
    localparam logic C_RNE = 1'b1;
`else
    localparam logic C_RNE = 1'b0;
`endif

    // Whole pipe advances together; a stall freezes every stage.
    logic w_advance;
    assign w_advance = ~out_valid | out_ready;
    assign in_ready  = w_advance;

    // ---------------- input capture ----------------
    logic             r0_valid;
    logic [C_W-1:0]   r0_a;
    logic [C_W-1:0]   r0_b;
    logic             r0_sub;

    // ---------------- stage 1: align ----------------
    logic                  w1_sa;
    logic                  w1_sb;
    logic                  w1_swap;
    logic [EXP_W-1:0]      w1_ea;
    logic [EXP_W-1:0]      w1_eb;
    logic [EXP_W-1:0]      w1_e_big;
    logic [EXP_W-1:0]      w1_e_small;
    logic [EXP_W-1:0]      w1_e_big_eff;
    logic [EXP_W-1:0]      w1_e_small_eff;
    logic [EXP_W-1:0]      w1_shift;
    logic [MAN_W-1:0]      w1_ma;
    logic [MAN_W-1:0]      w1_mb;
    logic [MAN_W-1:0]      w1_m_big;
    logic [MAN_W-1:0]      w1_m_small;
    logic [C_SIG_W-1:0]    w1_sig_big;
    logic [C_SIG_W-1:0]    w1_sig_small;
    logic [C_SIG_W-1:0]    w1_sig_aligned;
    logic [2*C_SIG_W-2:0]  w1_wide;
    logic                  w1_far;
    logic                  w1_nan;
    logic                  w1_eff_sub;
    logic                  w1_sign;

    always_comb begin
        {w1_sa, w1_ea, w1_ma} = r0_a;
        {w1_sb, w1_eb, w1_mb} = r0_b;
        w1_swap = {w1_eb, w1_mb} > {w1_ea, w1_ma};

        w1_e_big   = w1_swap ? w1_eb : w1_ea;
        w1_m_big   = w1_swap ? w1_mb : w1_ma;
        w1_e_small = w1_swap ? w1_ea : w1_eb;
        w1_m_small = w1_swap ? w1_ma : w1_mb;

        // Subnormals carry a zero hidden bit but behave as exponent 1.
        w1_e_big_eff   = (w1_e_big == '0)   ? C_EXP_ONE : w1_e_big;
        w1_e_small_eff = (w1_e_small == '0) ? C_EXP_ONE : w1_e_small;
        w1_sig_big     = {|w1_e_big,   w1_m_big,   3'b000};
        w1_sig_small   = {|w1_e_small, w1_m_small, 3'b000};

        w1_shift = w1_e_big_eff - w1_e_small_eff;
        w1_wide  = {w1_sig_small, {(C_SIG_W-1){1'b0}}} >> w1_shift;
        w1_far   = C_CMP_W'(w1_shift) >= C_CMP_W'(C_SIG_W - 1);

        // The lower half of w1_wide holds everything shifted past the window.
        if (w1_far) begin
            w1_sig_aligned = {{(C_SIG_W-1){1'b0}}, |w1_sig_small};
        end else begin
            w1_sig_aligned = {w1_wide[2*C_SIG_W-2:C_SIG_W],
                              w1_wide[C_SIG_W-1] | (|w1_wide[C_SIG_W-2:0])};
        end

        w1_nan     = (&w1_ea) | (&w1_eb);
        w1_eff_sub = r0_sub ^ w1_sa ^ w1_sb;
        w1_sign    = w1_swap ? (w1_sb ^ r0_sub) : w1_sa;
    end

    logic                r1_valid;
    logic                r1_nan;
    logic                r1_eff_sub;
    logic                r1_sign;
    logic [EXP_W-1:0]    r1_exp;
    logic [C_SIG_W-1:0]  r1_sig_a;
    logic [C_SIG_W-1:0]  r1_sig_b;

    // ---------------- stage 2: add/sub ----------------
    // Alignment guarantees sig_a >= sig_b, so the difference is never negative.
    logic [C_SUM_W-1:0]  w2_sum;

    always_comb begin
        if (r1_eff_sub) begin
            w2_sum = {1'b0, r1_sig_a} - {1'b0, r1_sig_b};
        end else begin
            w2_sum = {1'b0, r1_sig_a} + {1'b0, r1_sig_b};
        end
    end

    logic                r2_valid;
    logic                r2_nan;
    logic                r2_sign;
    logic [EXP_W-1:0]    r2_exp;
    logic [C_SUM_W-1:0]  r2_sum;

    // ---------------- stage 3: normalise / round ----------------
    logic [C_LZ_W-1:0]   w3_lz;
    logic [EXP_W-1:0]    w3_lim;
    logic [EXP_W-1:0]    w3_sh;
    logic [C_SIG_W-1:0]  w3_norm;
    logic [EXP_W:0]      w3_exp_n;
    logic [EXP_W:0]      w3_exp_enc;
    logic [EXP_W:0]      w3_exp_f;
    logic [MAN_W+1:0]    w3_rnd;
    logic [MAN_W-1:0]    w3_man_f;
    logic                w3_inc;
    logic                w3_ovf;
    logic                w3_zero;
    logic [C_W-1:0]      w3_result;
    logic                w3_exc;

    always_comb begin
        w3_lz = C_LZ_W'(C_SIG_W);
        for (int i = 0; i < C_SIG_W; i++) begin
            if (r2_sum[i]) begin
                w3_lz = C_LZ_W'(C_SIG_W - 1 - i);
            end
        end

        // Left shift is capped so the exponent never goes below 1.
        w3_lim = r2_exp - C_EXP_ONE;
        w3_sh  = (C_CMP_W'(w3_lz) > C_CMP_W'(w3_lim)) ? w3_lim : EXP_W'(w3_lz);

        if (r2_sum[C_SUM_W-1]) begin
            w3_norm  = {r2_sum[C_SUM_W-1:2], r2_sum[1] | r2_sum[0]};
            w3_exp_n = {1'b0, r2_exp} + {{EXP_W{1'b0}}, 1'b1};
        end else begin
            w3_norm  = r2_sum[C_SIG_W-1:0] << w3_sh;
            w3_exp_n = {1'b0, r2_exp} - {1'b0, w3_sh};
        end

        // No hidden bit after a capped shift means a subnormal encoding.
        w3_exp_enc = w3_norm[C_SIG_W-1] ? w3_exp_n : '0;

        w3_inc = C_RNE & w3_norm[2] & (w3_norm[1] | w3_norm[0] | w3_norm[3]);
        w3_rnd = {1'b0, w3_norm[C_SIG_W-1:3]} + (MAN_W+2)'(w3_inc);

        if (w3_rnd[MAN_W+1]) begin
            w3_exp_f = w3_exp_enc + {{EXP_W{1'b0}}, 1'b1};
            w3_man_f = w3_rnd[MAN_W:1];
        end else if (w3_rnd[MAN_W] && (w3_exp_enc == '0)) begin
            w3_exp_f = {{EXP_W{1'b0}}, 1'b1};
            w3_man_f = w3_rnd[MAN_W-1:0];
        end else begin
            w3_exp_f = w3_exp_enc;
            w3_man_f = w3_rnd[MAN_W-1:0];
        end

        w3_ovf  = w3_exp_f >= {1'b0, C_EXP_ONES};
        w3_zero = (r2_sum == '0);

        if (r2_nan) begin
            w3_result = {1'b0, C_EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};
        end else if (w3_zero) begin
            w3_result = '0;
        end else if (w3_ovf) begin
            w3_result = {r2_sign, C_EXP_ONES, {MAN_W{1'b0}}};
        end else begin
            w3_result = {r2_sign, w3_exp_f[EXP_W-1:0], w3_man_f};
        end
        w3_exc = r2_nan | w3_ovf;
    end

    // ---------------- pipeline registers ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r0_valid  <= 1'b0;
            r1_valid  <= 1'b0;
            r2_valid  <= 1'b0;
            out_valid <= 1'b0;
            result    <= '0;
            Exception <= 1'b0;
        end else if (w_advance) begin
            r0_valid   <= in_valid;
            r0_a       <= a_operand;
            r0_b       <= b_operand;
            r0_sub     <= AddBar_Sub;

            r1_valid   <= r0_valid;
            r1_nan     <= w1_nan;
            r1_eff_sub <= w1_eff_sub;
            r1_sign    <= w1_sign;
            r1_exp     <= w1_e_big_eff;
            r1_sig_a   <= w1_sig_big;
            r1_sig_b   <= w1_sig_aligned;

            r2_valid   <= r1_valid;
            r2_nan     <= r1_nan;
            r2_sign    <= r1_sign;
            r2_exp     <= r1_exp;
            r2_sum     <= w2_sum;

            out_valid  <= r2_valid;
            result     <= r2_valid ? w3_result : '0;
            Exception  <= r2_valid & w3_exc;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fp_add_sub_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp_add_sub_pipe
// Purpose  : Scoreboard bench for fp_add_sub_pipe, single and double precision.
// Revision : 1.0  initial release
// ============================================================================
module tb_fp_add_sub_pipe;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a_op;
    logic [31:0] b_op;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        exc;

    logic        d_in_valid;
    logic        d_in_ready;
    logic [63:0] d_a_op;
    logic [63:0] d_b_op;
    logic        d_sub;
    logic        d_out_valid;
    logic        d_out_ready;
    logic [63:0] d_result;
    logic        d_exc;

    typedef struct {
        logic [63:0] res;
        logic        exc;
        string       tag;
    } exp_t;

    exp_t sq[$];
    exp_t dq[$];
    int   checks = 0;
    int   errors = 0;

    fp_add_sub_pipe #(.EXP_W(8), .MAN_W(23)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a_operand(a_op), .b_operand(b_op), .AddBar_Sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .Exception(exc)
    );

    fp_add_sub_pipe #(.EXP_W(11), .MAN_W(52)) dut_d (
        .clk(clk), .rst_n(rst_n), .in_valid(d_in_valid), .in_ready(d_in_ready),
        .a_operand(d_a_op), .b_operand(d_b_op), .AddBar_Sub(d_sub),
        .out_valid(d_out_valid), .out_ready(d_out_ready),
        .result(d_result), .Exception(d_exc)
    );

    assign d_out_ready = 1'b1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic issue(input logic [31:0] aa, input logic [31:0] bb, input logic s,
                         input logic [31:0] er, input logic ee, input string tag);
        exp_t e;
        logic acc;
        acc = 1'b0;
        in_valid = 1'b1;
        a_op = aa;
        b_op = bb;
        sub = s;
        for (int k = 0; k < 64 && !acc; k++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        check({"accept ", tag}, 64'(acc), 64'd1);
        if (acc) begin
            e.res = 64'(er);
            e.exc = ee;
            e.tag = tag;
            sq.push_back(e);
        end
    endtask

    task automatic issue_d(input logic [63:0] aa, input logic [63:0] bb, input logic s,
                           input logic [63:0] er, input logic ee, input string tag);
        exp_t e;
        logic acc;
        acc = 1'b0;
        d_in_valid = 1'b1;
        d_a_op = aa;
        d_b_op = bb;
        d_sub = s;
        for (int k = 0; k < 64 && !acc; k++) begin
            @(negedge clk);
            acc = d_in_ready;
            @(posedge clk);
            #1;
        end
        d_in_valid = 1'b0;
        check({"accept ", tag}, 64'(acc), 64'd1);
        if (acc) begin
            e.res = er;
            e.exc = ee;
            e.tag = tag;
            dq.push_back(e);
        end
    endtask

    // Called right after an accepting edge; counts edges until out_valid.
    task automatic measure_latency(input string name);
        int lat;
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end while (!out_valid && lat < 10);
        check(name, 64'(lat), 64'd3);
    endtask

    task automatic drain();
        for (int k = 0; k < 100 && (sq.size() + dq.size()) != 0; k++) begin
            @(posedge clk);
        end
        #1;
        check("drain", 64'(sq.size() + dq.size()), 64'd0);
    endtask

    // Monitor: pops on every output transfer and checks stall stability.
    initial begin
        exp_t        e;
        logic        held_v;
        logic [31:0] held_r;
        logic        held_e;
        held_v = 1'b0;
        held_r = '0;
        held_e = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (held_v) begin
                    check("stall stable result", 64'(result), 64'(held_r));
                    check("stall stable exception", 64'(exc), 64'(held_e));
                end
                if (out_valid && out_ready) begin
                    if (sq.size() == 0) begin
                        check("unexpected sp output", 64'(out_valid), 64'd0);
                    end else begin
                        e = sq.pop_front();
                        check({"sp result ", e.tag}, 64'(result), e.res);
                        check({"sp exception ", e.tag}, 64'(exc), 64'(e.exc));
                    end
                end
                held_v = out_valid && !out_ready;
                held_r = result;
                held_e = exc;
                if (d_out_valid && d_out_ready) begin
                    if (dq.size() == 0) begin
                        check("unexpected dp output", 64'(d_out_valid), 64'd0);
                    end else begin
                        e = dq.pop_front();
                        check({"dp result ", e.tag}, d_result, e.res);
                        check({"dp exception ", e.tag}, 64'(d_exc), 64'(e.exc));
                    end
                end
            end else begin
                held_v = 1'b0;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    // {a, b, sub, expected result, expected exception}
    localparam int NV = 18;
    logic [31:0] va [NV];
    logic [31:0] vb [NV];
    logic        vs [NV];
    logic [31:0] vr [NV];
    logic        ve [NV];

    localparam int ND = 8;
    logic [63:0] da [ND];
    logic [63:0] db [ND];
    logic        ds [ND];
    logic [63:0] dr [ND];
    logic        de [ND];

    logic [31:0] st_a [10];
    logic [31:0] st_r [10];

    initial begin
        va[0]  = 32'h3F800000; vb[0]  = 32'h40000000; vs[0]  = 0; vr[0]  = 32'h40400000; ve[0]  = 0;
        va[1]  = 32'h3F800000; vb[1]  = 32'h3F800000; vs[1]  = 1; vr[1]  = 32'h00000000; ve[1]  = 0;
        va[2]  = 32'h3F800000; vb[2]  = 32'h40000000; vs[2]  = 1; vr[2]  = 32'hBF800000; ve[2]  = 0;
        va[3]  = 32'h7F7FFFFF; vb[3]  = 32'h7F7FFFFF; vs[3]  = 0; vr[3]  = 32'h7F800000; ve[3]  = 1;
        va[4]  = 32'h7F800000; vb[4]  = 32'h3F800000; vs[4]  = 0; vr[4]  = 32'h7FC00000; ve[4]  = 1;
        va[5]  = 32'h3F800001; vb[5]  = 32'h33800000; vs[5]  = 0; ve[5]  = 0;
        va[6]  = 32'h3F800000; vb[6]  = 32'h33800000; vs[6]  = 0; vr[6]  = 32'h3F800000; ve[6]  = 0;
        va[7]  = 32'h00000001; vb[7]  = 32'h00000001; vs[7]  = 0; vr[7]  = 32'h00000002; ve[7]  = 0;
        va[8]  = 32'h00800000; vb[8]  = 32'h00000001; vs[8]  = 1; vr[8]  = 32'h007FFFFF; ve[8]  = 0;
        va[9]  = 32'h00400000; vb[9]  = 32'h00400000; vs[9]  = 0; vr[9]  = 32'h00800000; ve[9]  = 0;
        va[10] = 32'hBFC00000; vb[10] = 32'h3E800000; vs[10] = 0; vr[10] = 32'hBFA00000; ve[10] = 0;
        va[11] = 32'hC0000000; vb[11] = 32'h3F800000; vs[11] = 1; vr[11] = 32'hC0400000; ve[11] = 0;
        va[12] = 32'h4B800000; vb[12] = 32'h3F800000; vs[12] = 0; vr[12] = 32'h4B800000; ve[12] = 0;
        va[13] = 32'h3F800000; vb[13] = 32'h00000001; vs[13] = 0; vr[13] = 32'h3F800000; ve[13] = 0;
        va[14] = 32'h7F7FFFFF; vb[14] = 32'h73000000; vs[14] = 0;
        va[15] = 32'h3F800000; vb[15] = 32'hFF800000; vs[15] = 1; vr[15] = 32'h7FC00000; ve[15] = 1;
        va[16] = 32'h3F800000; vb[16] = 32'hBF800000; vs[16] = 0; vr[16] = 32'h00000000; ve[16] = 0;
        va[17] = 32'hBF800000; vb[17] = 32'hBF800000; vs[17] = 1; vr[17] = 32'h00000000; ve[17] = 0;

        da[0] = 64'h3FF0000000000000; db[0] = 64'h4000000000000000; ds[0] = 0; dr[0] = 64'h4008000000000000; de[0] = 0;
        da[1] = 64'h3FF0000000000000; db[1] = 64'h4000000000000000; ds[1] = 1; dr[1] = 64'hBFF0000000000000; de[1] = 0;
        da[2] = 64'h3FF0000000000000; db[2] = 64'h3FF0000000000000; ds[2] = 1; dr[2] = 64'h0000000000000000; de[2] = 0;
        da[3] = 64'h7FEFFFFFFFFFFFFF; db[3] = 64'h7FEFFFFFFFFFFFFF; ds[3] = 0; dr[3] = 64'h7FF0000000000000; de[3] = 1;
        da[4] = 64'h7FF0000000000000; db[4] = 64'h3FF0000000000000; ds[4] = 0; dr[4] = 64'h7FF8000000000000; de[4] = 1;
        da[5] = 64'h3FF0000000000001; db[5] = 64'h3CA0000000000000; ds[5] = 0; de[5] = 0;
        da[6] = 64'h3FF0000000000000; db[6] = 64'h3CA0000000000000; ds[6] = 0; dr[6] = 64'h3FF0000000000000; de[6] = 0;
        da[7] = 64'h0000000000000001; db[7] = 64'h0000000000000001; ds[7] = 0; dr[7] = 64'h0000000000000002; de[7] = 0;

`ifdef FP_ADDSUB_RNE_EN
        vr[5]  = 32'h3F800002;
        vr[14] = 32'h7F800000; ve[14] = 1;
        dr[5]  = 64'h3FF0000000000002;
`else
        vr[5]  = 32'h3F800001;
        vr[14] = 32'h7F7FFFFF; ve[14] = 0;
        dr[5]  = 64'h3FF0000000000001;
`endif

        // Stream: k + 1.0 for k = 1..10
        st_a[0] = 32'h3F800000; st_r[0] = 32'h40000000;
        st_a[1] = 32'h40000000; st_r[1] = 32'h40400000;
        st_a[2] = 32'h40400000; st_r[2] = 32'h40800000;
        st_a[3] = 32'h40800000; st_r[3] = 32'h40A00000;
        st_a[4] = 32'h40A00000; st_r[4] = 32'h40C00000;
        st_a[5] = 32'h40C00000; st_r[5] = 32'h40E00000;
        st_a[6] = 32'h40E00000; st_r[6] = 32'h41000000;
        st_a[7] = 32'h41000000; st_r[7] = 32'h41100000;
        st_a[8] = 32'h41100000; st_r[8] = 32'h41200000;
        st_a[9] = 32'h41200000; st_r[9] = 32'h41300000;

        rst_n = 1'b0;
        in_valid = 1'b0; a_op = '0; b_op = '0; sub = 1'b0;
        d_in_valid = 1'b0; d_a_op = '0; d_b_op = '0; d_sub = 1'b0;
        out_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        // Offered during the reset cycle: must never be accepted.
        in_valid = 1'b1; a_op = 32'h3F800000; b_op = 32'h3F800000;
        @(negedge clk);
        check("reset out_valid", 64'(out_valid), 64'd0);
        check("reset result", 64'(result), 64'd0);
        check("reset exception", 64'(exc), 64'd0);
        check("reset in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        in_valid = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("idle after reset out_valid", 64'(out_valid), 64'd0);
        end
        @(posedge clk);
        #1;

        // Directed single precision; first op also measures latency.
        issue(va[0], vb[0], vs[0], vr[0], ve[0], "v0");
        measure_latency("latency first op");
        @(posedge clk);
        #1;
        for (int i = 1; i < NV; i++) begin
            issue(va[i], vb[i], vs[i], vr[i], ve[i], $sformatf("v%0d", i));
        end
        for (int i = 0; i < ND; i++) begin
            issue_d(da[i], db[i], ds[i], dr[i], de[i], $sformatf("d%0d", i));
        end
        drain();

        // Back-to-back stream with a 4-cycle output stall.
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    issue(st_a[i], 32'h3F800000, 1'b0, st_r[i], 1'b0, $sformatf("s%0d", i));
                end
            end
            begin
                repeat (5) @(posedge clk);
                #1;
                out_ready = 1'b0;
                for (int k = 0; k < 4; k++) begin
                    @(negedge clk);
                    check("stalled in_ready", 64'(in_ready), 64'd0);
                    check("stalled out_valid", 64'(out_valid), 64'd1);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset with three ops in flight: none may ever emerge.
        for (int i = 0; i < 3; i++) begin
            issue(st_a[i], 32'h3F800000, 1'b0, st_r[i], 1'b0, $sformatf("r%0d", i));
        end
        rst_n = 1'b0;
        sq.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("flush out_valid", 64'(out_valid), 64'd0);
        check("flush in_ready", 64'(in_ready), 64'd1);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("flush stays empty", 64'(out_valid), 64'd0);
        end
        @(posedge clk);
        #1;
        issue(va[2], vb[2], vs[2], vr[2], ve[2], "post reset");
        measure_latency("latency after reset");
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
